// File: rtl/sevenseg_pkg.sv
// Shared types and hex segment patterns for the multiplexed display driver.
// Patterns are active-high {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // dp position when seg and dp are packed into one byte
  localparam int SEG_DP_BIT = 7;

  localparam logic [15:0][6:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex_decode(input logic [3:0] nib);
    return seg_t'(HEX_PAT[nib]);
  endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Refresh prescaler and digit index for the display scan.
// slot_end marks the last cycle of each digit slot.
import sevenseg_pkg::*;

module sevenseg_scan_timer #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          pcnt_blank,
  output logic          slot_end
);

  localparam logic [PW-1:0] LAST_P = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] pcnt;

  assign slot_end   = (pcnt == LAST_P);
  assign pcnt_blank = ({1'b0, pcnt} < (PW+1)'(BLANK_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= (idx == LAST_I) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Multiplexed N-digit seven-segment driver with shadow data,
// leading-zero suppression and anti-ghosting anode blanking.
import sevenseg_pkg::*;

module sevenseg_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    lz_sup,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [IW-1:0]           idx;
  logic                    pcnt_blank;
  logic                    slot_end;

  logic [NUM_DIGITS-1:0] supp;
  logic [3:0]            nib;
  seg_t                  pat;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  run;

  sevenseg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .pcnt_blank(pcnt_blank),
    .slot_end  (slot_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
    end else if (load) begin
      sh_data <= data;
      sh_dp   <= dp;
    end
  end

  // run stays high while this digit and all above it are zero
  always_comb begin
    run  = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run     = run & (sh_data[4*k +: 4] == 4'h0);
      supp[k] = lz_sup & run & (k != 0);
    end
  end

  always_comb begin
    nib    = sh_data[4*int'(idx) +: 4];
    pat    = supp[idx] ? SEG_BLANK : hex_decode(nib);
    an_act = pcnt_blank ? '0 : (NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= {7{INV}};
      dp_out     <= INV;
      an         <= {NUM_DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      seg        <= pat ^ {7{INV}};
      dp_out     <= sh_dp[idx] ^ INV;
      an         <= an_act ^ {NUM_DIGITS{INV}};
      frame_done <= slot_end && (idx == LAST_I);
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench: 4-digit active-low driver plus a 3-digit
// active-high instance with an odd divider for wrap timing.
module tb_sevenseg_mux_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] data   = '0;
  logic [3:0]  dp     = '0;
  logic        load   = 1'b0;
  logic        lz_sup = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  logic [11:0] data_o = '0;
  logic [2:0]  dp_o   = '0;
  logic        load_o = 1'b0;
  logic        lz_o   = 1'b0;
  logic [6:0]  seg_o;
  logic        dpo;
  logic [2:0]  an_o;
  logic        fd_o;

  int vectors = 0;
  int errors  = 0;

  sevenseg_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4),
    .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp),
    .load(load), .lz_sup(lz_sup), .seg(seg),
    .dp_out(dp_out), .an(an), .frame_done(frame_done)
  );

  sevenseg_mux_driver #(
    .NUM_DIGITS(3), .REFRESH_DIV(7),
    .BLANK_CYCLES(2), .ACTIVE_LOW(0)
  ) u_odd (
    .clk(clk), .rst(rst), .data(data_o), .dp(dp_o),
    .load(load_o), .lz_sup(lz_o), .seg(seg_o),
    .dp_out(dpo), .an(an_o), .frame_done(fd_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    load = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    vectors++;
    if (seg !== 7'h7F || dp_out !== 1'b1 || an !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_vals seg=%h dp=%b an=%h fd=%b want 7f 1 f 0", seg, dp_out, an, frame_done);
    end
    vectors++;
    if (seg_o !== 7'h00 || dpo !== 1'b0 || an_o !== 3'b000 || fd_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_vals_hi seg=%h dp=%b an=%b fd=%b want 00 0 000 0", seg_o, dpo, an_o, fd_o);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL rel_blank an=%h want f", an);
    end
    tick();
    vectors++;
    if (an !== 4'hE) begin
      errors++;
      $display("FAIL rel_first an=%h want e", an);
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (seg !== 7'h7F || dp_out !== 1'b1 || an !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid seg=%h dp=%b an=%h want 7f 1 f", seg, dp_out, an);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid_blank an=%h want f", an);
    end
    tick();
    vectors++;
    if (an !== 4'hE) begin
      errors++;
      $display("FAIL rst_mid_first an=%h want e", an);
    end
  endtask

  task automatic test_scan;
    logic [6:0] tab [4] = '{7'h40, 7'h79, 7'h0E, 7'h00};
    logic [3:0] ea;
    logic       ef;
    int p, i;
    do_reset();
    data = 16'h8F10; dp = 4'h0; lz_sup = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 2; j <= 32; j++) begin
      tick();
      p  = (j - 1) % 4;
      i  = ((j - 1) / 4) % 4;
      ea = (p == 0) ? 4'hF : ~(4'b0001 << i);
      ef = (j % 16 == 0);
      vectors++;
      if (an !== ea) begin
        errors++;
        $display("FAIL scan_an cyc=%0d an=%h want %h", j, an, ea);
      end
      vectors++;
      if (seg !== tab[i]) begin
        errors++;
        $display("FAIL scan_seg cyc=%0d seg=%h want %h", j, seg, tab[i]);
      end
      vectors++;
      if (frame_done !== ef) begin
        errors++;
        $display("FAIL scan_fd cyc=%0d fd=%b want %b", j, frame_done, ef);
      end
    end
  endtask

  task automatic test_lz;
    logic [6:0] on  [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [6:0] off [4] = '{7'h40, 7'h12, 7'h40, 7'h40};
    logic [6:0] es;
    logic       ed;
    int i;
    do_reset();
    data = 16'h0050; dp = 4'b1000; lz_sup = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 2; j <= 32; j++) begin
      if (j == 17) lz_sup = 1'b0;
      tick();
      i  = ((j - 1) / 4) % 4;
      es = (j <= 16) ? on[i] : off[i];
      ed = (i != 3);
      vectors++;
      if (seg !== es || dp_out !== ed) begin
        errors++;
        $display("FAIL lz cyc=%0d seg=%h dp=%b want %h %b", j, seg, dp_out, es, ed);
      end
    end
    lz_sup = 1'b0;
  endtask

  task automatic test_coherent;
    logic [6:0] tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int i;
    do_reset();
    data = 16'h1234; dp = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    data = 16'h5678;
    for (int j = 2; j <= 19; j++) begin
      tick();
      i = ((j - 1) / 4) % 4;
      vectors++;
      if (seg !== tab[i]) begin
        errors++;
        $display("FAIL hold cyc=%0d seg=%h want %h", j, seg, tab[i]);
      end
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if (seg !== 7'h19) begin
      errors++;
      $display("FAIL load_edge seg=%h want 19", seg);
    end
    tick();
    vectors++;
    if (seg !== 7'h78 || an !== 4'hF) begin
      errors++;
      $display("FAIL load_next seg=%h an=%h want 78 f", seg, an);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    dp = 4'h0; load = 1'b1;
    data = 16'h0001;
    tick();
    data = 16'h0002;
    tick();
    data = 16'h0003;
    tick();
    load = 1'b0;
    data = 16'h0009;
    vectors++;
    if (seg !== 7'h24) begin
      errors++;
      $display("FAIL b2b_mid seg=%h want 24", seg);
    end
    tick();
    vectors++;
    if (seg !== 7'h30) begin
      errors++;
      $display("FAIL b2b_last seg=%h want 30", seg);
    end
    repeat (13) tick();
    vectors++;
    if (seg !== 7'h30 || an !== 4'hF) begin
      errors++;
      $display("FAIL b2b_persist seg=%h an=%h want 30 f", seg, an);
    end
  endtask

  task automatic test_wrap;
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    do_reset();
    for (int k = 1; k <= 100 && !got; k++) begin
      tick();
      if (k == 2) begin
        vectors++;
        if (an_o !== 3'b000) begin
          errors++;
          $display("FAIL odd_blank an=%b want 000", an_o);
        end
      end
      if (k == 3) begin
        vectors++;
        if (an_o !== 3'b001 || seg_o !== 7'h3F || dpo !== 1'b0) begin
          errors++;
          $display("FAIL odd_first an=%b seg=%h dp=%b want 001 3f 0", an_o, seg_o, dpo);
        end
      end
      if (fd_o) begin
        got = 1'b1;
        n   = k;
      end
    end
    vectors++;
    if (!got || n != 21) begin
      errors++;
      $display("FAIL odd_first_fd got=%b cyc=%0d want 21", got, n);
    end
    got = 1'b0;
    n   = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      tick();
      if (fd_o) begin
        got = 1'b1;
        n   = k;
      end
    end
    vectors++;
    if (!got || n != 21) begin
      errors++;
      $display("FAIL odd_period got=%b cyc=%0d want 21", got, n);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_coherent();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
